display_scan_ctrl: RTL and testbench

Sequencer for the front-panel multiplexed display. It scans the 8 digit slots (DIG1..DIG8, slots 7/8 also carry discrete status LEDs). For each slot it fetches a 72-bit row word ({rowA,rowB,rowC}) from the panel formatter and hands it to the serial shift engine through a start/done handshake. It then holds the slot lit for a dwell period and blanks before moving to the next slot. It also decides when the formatter may re-snapshot CPU state, so one frame never mixes old and new register values.

---
 rtl/display_pkg.sv | 34 +++
 rtl/display_dwell_timer.sv | 36 +++
 rtl/display_scan_ctrl.sv | 175 +++++++++++++++++
 tb/tb_display_scan_ctrl.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : display_pkg
// Description : Shared types and default timing for the front-panel display
//               scan sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package display_pkg;

    localparam int DIGITS            = 8;
    localparam int ROW_BITS          = 72;
    localparam int DEF_DWELL_CYCLES  = 4096;
    localparam int DEF_BLANK_CYCLES  = 16;
    localparam int DEF_SHIFT_TIMEOUT = 1024;

    // Scan sequencer states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_SHIFT = 3'd2,
        ST_DWELL = 3'd3,
        ST_BLANK = 3'd4
    } scan_state_t;

    // Largest of three timing values, used to size the shared slot timer
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/display_dwell_timer.sv
`default_nettype none
// ============================================================================
// Module      : display_dwell_timer
// Description : Loadable down-counter with a terminal-count flag. Shared by the
//               dwell, blank and shift-timeout intervals of the scan sequencer.
//               o_tc is high while the count is zero; a load of N gives a
//               terminal count on the (N+1)th cycle after the load.
// Revision    : 1.0 - initial release
// ============================================================================
module display_dwell_timer #(
    parameter int WIDTH = 13
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_tc
);

    logic [WIDTH-1:0] r_count;

    // Load has priority; otherwise count down and park at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_tc = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/display_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : display_scan_ctrl
// Description : Multiplexed front-panel display sequencer. Per slot: fetch the
//               row word, hand it to the shift engine, dwell lit, blank, then
//               advance. Snapshot pulses only at frame boundaries / IDLE exit
//               so a frame never mixes old and new CPU state.
// Revision    : 1.0 - initial release
// ============================================================================
module display_scan_ctrl #(
    parameter int NUM_DIGITS    = display_pkg::DIGITS,
    parameter int DWELL_CYCLES  = display_pkg::DEF_DWELL_CYCLES,
    parameter int BLANK_CYCLES  = display_pkg::DEF_BLANK_CYCLES,
    parameter int SHIFT_TIMEOUT = display_pkg::DEF_SHIFT_TIMEOUT,
    parameter int ROW_BITS      = display_pkg::ROW_BITS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_enable,
    input  logic                i_leds_valid,
    input  logic [ROW_BITS-1:0] i_digit_bits,
    input  logic                i_shift_done,
    output logic [2:0]          o_digit_sel,
    output logic [ROW_BITS-1:0] o_display_bits,
    output logic                o_shift_start,
    output logic                o_blank_n,
    output logic                o_snap,
    output logic                o_frame_tick,
    output logic                o_shift_err
);

    import display_pkg::*;

    localparam int         CNT_W      = $clog2(max3(DWELL_CYCLES, BLANK_CYCLES, SHIFT_TIMEOUT) + 1);
    localparam int         BLANK_LOAD = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;
    localparam logic [2:0] LAST_SLOT  = 3'(NUM_DIGITS - 1);

    scan_state_t         r_state;
    scan_state_t         w_next_state;
    logic                w_advance;
    logic                w_tc;
    logic                w_tmr_load;
    logic [CNT_W-1:0]    w_tmr_val;
    logic                w_timeout;
    logic                w_frame_end;
    logic                w_idle_exit;
    logic [2:0]          r_digit_sel;
    logic [ROW_BITS-1:0] r_display_bits;
    logic                r_shift_start;
    logic                r_snap;
    logic                r_frame_tick;
    logic                r_shift_err;

    display_dwell_timer #(
        .WIDTH (CNT_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_tc       (w_tc)
    );

    // A shift that never reports done is abandoned on the last allowed cycle
    assign w_timeout   = (r_state == ST_SHIFT) && !i_shift_done && w_tc;
    assign w_frame_end = w_advance && (r_digit_sel == LAST_SLOT);
    assign w_idle_exit = (r_state == ST_IDLE) && i_enable;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; enable is only honoured at slot advance so a lit slot always finishes
    always_comb begin
        w_next_state = r_state;
        w_advance    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (i_enable) w_next_state = ST_FETCH;
            end
            ST_FETCH: begin
                w_next_state = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (i_shift_done) begin
                    w_next_state = ST_DWELL;
                end else if (w_tc) begin
                    if (BLANK_CYCLES == 0) w_advance = 1'b1;
                    else                   w_next_state = ST_BLANK;
                end
            end
            ST_DWELL: begin
                if (w_tc) begin
                    if (BLANK_CYCLES == 0) w_advance = 1'b1;
                    else                   w_next_state = ST_BLANK;
                end
            end
            ST_BLANK: begin
                if (w_tc) w_advance = 1'b1;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
        if (w_advance) begin
            w_next_state = i_enable ? ST_FETCH : ST_IDLE;
        end
    end

    // Outputs and timer loads; the timer is reloaded on entry to each timed state
    always_comb begin
        o_blank_n  = (r_state == ST_DWELL);
        w_tmr_load = 1'b0;
        w_tmr_val  = '0;
        if (w_next_state != r_state) begin
            unique case (w_next_state)
                ST_SHIFT: begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = CNT_W'(SHIFT_TIMEOUT - 1);
                end
                ST_DWELL: begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = CNT_W'(DWELL_CYCLES - 1);
                end
                ST_BLANK: begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = CNT_W'(BLANK_LOAD);
                end
                default: begin
                    w_tmr_load = 1'b0;
                end
            endcase
        end
    end

    // Slot datapath: word capture, handshake pulse, slot index, frame/snapshot pulses, sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digit_sel    <= '0;
            r_display_bits <= '0;
            r_shift_start  <= 1'b0;
            r_snap         <= 1'b0;
            r_frame_tick   <= 1'b0;
            r_shift_err    <= 1'b0;
        end else begin
            if (r_state == ST_FETCH) begin
                r_display_bits <= i_digit_bits;
            end
            r_shift_start <= (r_state == ST_FETCH);
            if (w_advance) begin
                if (w_frame_end || !i_enable) r_digit_sel <= '0;
                else                          r_digit_sel <= r_digit_sel + 3'd1;
            end
            r_frame_tick <= w_frame_end;
            r_snap       <= i_leds_valid && (w_frame_end || w_idle_exit);
            if (w_timeout) begin
                r_shift_err <= 1'b1;
            end
        end
    end

    assign o_digit_sel    = r_digit_sel;
    assign o_display_bits = r_display_bits;
    assign o_shift_start  = r_shift_start;
    assign o_snap         = r_snap;
    assign o_frame_tick   = r_frame_tick;
    assign o_shift_err    = r_shift_err;

endmodule
`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_display_scan_ctrl
// Description : Self-checking bench for display_scan_ctrl with a shift-engine
//               model, a combinational formatter table and a slot-timing
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_display_scan_ctrl;

    localparam int ND = 8;
    localparam int DW = 4;
    localparam int BL = 2;
    localparam int TO = 8;
    localparam int RB = 72;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          leds_valid;
    logic [RB-1:0] digit_bits;
    logic          shift_done;
    logic [2:0]    o_digit_sel;
    logic [RB-1:0] o_display_bits;
    logic          o_shift_start;
    logic          o_blank_n;
    logic          o_snap;
    logic          o_frame_tick;
    logic          o_shift_err;

    always #5 clk = ~clk;

    display_scan_ctrl #(
        .NUM_DIGITS    (ND),
        .DWELL_CYCLES  (DW),
        .BLANK_CYCLES  (BL),
        .SHIFT_TIMEOUT (TO),
        .ROW_BITS      (RB)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_enable       (enable),
        .i_leds_valid   (leds_valid),
        .i_digit_bits   (digit_bits),
        .i_shift_done   (shift_done),
        .o_digit_sel    (o_digit_sel),
        .o_display_bits (o_display_bits),
        .o_shift_start  (o_shift_start),
        .o_blank_n      (o_blank_n),
        .o_snap         (o_snap),
        .o_frame_tick   (o_frame_tick),
        .o_shift_err    (o_shift_err)
    );

    // Formatter: row word for the selected slot
    logic [RB-1:0] row_tbl [ND];
    assign digit_bits = row_tbl[o_digit_sel];

    // Shift engine behaviour per slot: lat<0 never answers, 0 answers in the start cycle
    int lat_tbl   [ND];
    int stray_tbl [ND];
    int pend_cnt;
    int stray_cnt;

    // Observation log
    int            cyc;
    int            start_cyc  [$];
    int            start_slot [$];
    logic [RB-1:0] start_bits [$];
    int            tick_q     [$];
    int            snap_q     [$];
    int            lit_cnt    [ND];
    int            err_cyc;

    int total;
    int bad;

    // Reference model: cycles from one shift_start to the next for a slot
    function automatic int slot_time(input int lat);
        if (lat >= 0) return 1 + (lat + 1) + DW + BL; // fetch, shift wait, dwell, blank
        else          return 1 + TO + BL;             // fetch, full timeout, blank
    endfunction

    function automatic logic [RB-1:0] rand_row();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[RB-1:0];
    endfunction

    task automatic clear_log();
        start_cyc.delete();
        start_slot.delete();
        start_bits.delete();
        tick_q.delete();
        snap_q.delete();
        for (int i = 0; i < ND; i++) lit_cnt[i] = 0;
        err_cyc = -1;
    endtask

    // One clock: sample outputs mid-cycle, then update the shift engine model
    task automatic step();
        @(negedge clk);
        cyc++;
        if (o_shift_start) begin
            start_cyc.push_back(cyc);
            start_slot.push_back(int'(o_digit_sel));
            start_bits.push_back(o_display_bits);
        end
        if (o_blank_n)    lit_cnt[o_digit_sel]++;
        if (o_frame_tick) tick_q.push_back(cyc);
        if (o_snap)       snap_q.push_back(cyc);
        if (o_shift_err && err_cyc < 0) err_cyc = cyc;
        shift_done = 1'b0;
        if (!rst_n) begin
            pend_cnt  = 0;
            stray_cnt = 0;
        end else begin
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) shift_done = 1'b1;
            end
            if (stray_cnt > 0) begin
                stray_cnt--;
                if (stray_cnt == 0) shift_done = 1'b1;
            end
            if (o_shift_start) begin
                if (lat_tbl[o_digit_sel] == 0) shift_done = 1'b1;
                else if (lat_tbl[o_digit_sel] > 0) pend_cnt = lat_tbl[o_digit_sel];
                if (stray_tbl[o_digit_sel] > 0) stray_cnt = stray_tbl[o_digit_sel];
            end
        end
    endtask

    task automatic run_starts(input int n, input string name);
        int guard;
        guard = 0;
        while (start_cyc.size() < n && guard < 2000) begin
            step();
            guard++;
        end
        total++;
        if (start_cyc.size() < n) begin
            bad++;
            $display("FAIL %s: shift_start count %0d, required %0d", name, start_cyc.size(), n);
        end
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        enable     = 1'b0;
        leds_valid = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        clear_log();
    endtask

    task automatic set_slots(input int lat_lo, input int lat_hi, input int stray);
        for (int i = 0; i < ND; i++) begin
            row_tbl[i]   = rand_row();
            lat_tbl[i]   = $urandom_range(lat_hi, lat_lo);
            stray_tbl[i] = stray;
        end
    endtask

    task automatic test_reset();
        int viol;
        set_slots(3, 3, -1);
        do_reset();
        enable = 1'b1;
        run_starts(1, "reset_pre");
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({o_shift_start, o_blank_n, o_snap, o_frame_tick, o_shift_err, o_digit_sel} !== 8'd0) begin
            bad++;
            $display("FAIL reset_async_ctl: got %b, required 0", {o_shift_start, o_blank_n, o_snap, o_frame_tick, o_shift_err, o_digit_sel});
        end
        total++;
        if (o_display_bits !== '0) begin
            bad++;
            $display("FAIL reset_async_bits: got %h, required 0", o_display_bits);
        end
        enable = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        clear_log();
        viol = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if ({o_shift_start, o_blank_n, o_snap, o_frame_tick, o_shift_err, o_digit_sel} !== 8'd0 ||
                o_display_bits !== '0) viol++;
        end
        total++;
        if (viol != 0 || start_cyc.size() != 0) begin
            bad++;
            $display("FAIL reset_idle: active cycles %0d starts %0d, required 0 and 0", viol, start_cyc.size());
        end
    endtask

    task automatic test_full_frame();
        for (int i = 0; i < ND; i++) begin
            row_tbl[i]   = RB'(i * 'h111);
            lat_tbl[i]   = 5;
            stray_tbl[i] = -1;
        end
        do_reset();
        enable     = 1'b1;
        leds_valid = 1'b1;
        run_starts(ND + 1, "frame_run");
        for (int k = 0; k < ND && k + 1 < start_cyc.size(); k++) begin
            total++;
            if (start_slot[k] != k || start_bits[k] !== RB'(k * 'h111)) begin
                bad++;
                $display("FAIL frame_word[%0d]: slot %0d bits %h, required slot %0d bits %h", k, start_slot[k], start_bits[k], k, RB'(k * 'h111));
            end
            total++;
            if (start_cyc[k+1] - start_cyc[k] != slot_time(5)) begin
                bad++;
                $display("FAIL frame_gap[%0d]: got %0d, required %0d", k, start_cyc[k+1] - start_cyc[k], slot_time(5));
            end
            total++;
            if (lit_cnt[k] != DW) begin
                bad++;
                $display("FAIL frame_lit[%0d]: got %0d, required %0d", k, lit_cnt[k], DW);
            end
        end
        total++;
        if (tick_q.size() != 1 || start_cyc.size() < ND + 1 || tick_q[0] != start_cyc[ND] - 1) begin
            bad++;
            $display("FAIL frame_tick: ticks %0d, required 1 just before the next frame", tick_q.size());
        end
        total++;
        if (start_slot.size() < ND + 1 || start_slot[ND] != 0 || o_shift_err !== 1'b0) begin
            bad++;
            $display("FAIL frame_wrap: next slot %0d err %b, required 0 and 0", (start_slot.size() > ND) ? start_slot[ND] : -1, o_shift_err);
        end
    endtask

    task automatic test_snapshot();
        set_slots(1, 6, -1);
        do_reset();
        enable     = 1'b1;
        leds_valid = 1'b1;
        step();
        leds_valid = 1'b0;
        run_starts(ND + 1, "snap_f1");
        leds_valid = 1'b1;
        run_starts(2 * ND + 1, "snap_f2");
        for (int k = 0; k < 2 * ND && k + 1 < start_cyc.size(); k++) begin
            total++;
            if (start_cyc[k+1] - start_cyc[k] != slot_time(lat_tbl[k % ND]) || start_bits[k] !== row_tbl[k % ND]) begin
                bad++;
                $display("FAIL snap_slot[%0d]: gap %0d bits %h, required %0d %h", k, start_cyc[k+1] - start_cyc[k], start_bits[k], slot_time(lat_tbl[k % ND]), row_tbl[k % ND]);
            end
        end
        if (start_cyc.size() >= 2 * ND + 1) begin
            total++;
            if (snap_q.size() != 2 || snap_q[0] != start_cyc[0] - 1 || snap_q[1] != start_cyc[2*ND] - 1) begin
                bad++;
                $display("FAIL snap_pulses: count %0d, required 2 (IDLE exit and end of frame 2)", snap_q.size());
            end
            total++;
            if (tick_q.size() != 2 || tick_q[0] != start_cyc[ND] - 1 || tick_q[1] != start_cyc[2*ND] - 1) begin
                bad++;
                $display("FAIL snap_ticks: count %0d, required 2 at frame ends", tick_q.size());
            end
        end
    endtask

    task automatic test_timeout();
        set_slots(1, 4, -1);
        lat_tbl[3] = -1;
        do_reset();
        enable     = 1'b1;
        leds_valid = 1'b1;
        run_starts(2 * ND + 1, "to_run");
        for (int k = 0; k < 2 * ND && k + 1 < start_cyc.size(); k++) begin
            total++;
            if (start_slot[k] != k % ND || start_cyc[k+1] - start_cyc[k] != slot_time(lat_tbl[k % ND])) begin
                bad++;
                $display("FAIL to_seq[%0d]: slot %0d gap %0d, required %0d %0d", k, start_slot[k], start_cyc[k+1] - start_cyc[k], k % ND, slot_time(lat_tbl[k % ND]));
            end
        end
        total++;
        if (start_cyc.size() < 4 || err_cyc != start_cyc[3] + TO) begin
            bad++;
            $display("FAIL to_err_time: err at %0d, required %0d", err_cyc, (start_cyc.size() > 3) ? start_cyc[3] + TO : -1);
        end
        for (int i = 0; i < ND; i++) begin
            total++;
            if (lit_cnt[i] != ((i == 3) ? 0 : 2 * DW)) begin
                bad++;
                $display("FAIL to_lit[%0d]: got %0d, required %0d", i, lit_cnt[i], (i == 3) ? 0 : 2 * DW);
            end
        end
        total++;
        if (o_shift_err !== 1'b1) begin
            bad++;
            $display("FAIL to_sticky: got %b, required 1", o_shift_err);
        end
    endtask

    task automatic test_enable_drop();
        int guard;
        int en_cyc;
        set_slots(1, 6, -1);
        do_reset();
        enable     = 1'b1;
        leds_valid = 1'b0;
        guard      = 0;
        while (!(o_blank_n && o_digit_sel == 3'd2) && guard < 500) begin
            step();
            guard++;
        end
        enable = 1'b0;
        repeat (60) step();
        total++;
        if (start_cyc.size() != 3 || lit_cnt[0] != DW || lit_cnt[1] != DW || lit_cnt[2] != DW) begin
            bad++;
            $display("FAIL drop_finish: starts %0d lit2 %0d, required 3 and %0d", start_cyc.size(), lit_cnt[2], DW);
        end
        total++;
        if (o_digit_sel !== 3'd0 || o_blank_n !== 1'b0 || tick_q.size() != 0) begin
            bad++;
            $display("FAIL drop_idle: sel %0d blank_n %b ticks %0d, required 0 0 0", o_digit_sel, o_blank_n, tick_q.size());
        end
        leds_valid = 1'b1;
        en_cyc     = cyc;
        enable     = 1'b1;
        run_starts(4, "drop_restart");
        total++;
        if (start_cyc.size() < 4 || start_slot[3] != 0 || start_cyc[3] - en_cyc != 2 || start_bits[3] !== row_tbl[0]) begin
            bad++;
            $display("FAIL drop_restart: restart slot/latency wrong, required slot 0 after 2 cycles");
        end
        total++;
        if (snap_q.size() != 1 || snap_q[0] != en_cyc + 1) begin
            bad++;
            $display("FAIL drop_snap: count %0d, required 1 at %0d", snap_q.size(), en_cyc + 1);
        end
    endtask

    task automatic test_same_cycle();
        set_slots(0, 0, 2);
        do_reset();
        enable     = 1'b1;
        leds_valid = 1'b0;
        run_starts(ND + 1, "same_run");
        for (int k = 0; k < ND && k + 1 < start_cyc.size(); k++) begin
            total++;
            if (start_cyc[k+1] - start_cyc[k] != slot_time(0) || lit_cnt[k] != DW) begin
                bad++;
                $display("FAIL same_slot[%0d]: gap %0d lit %0d, required %0d %0d", k, start_cyc[k+1] - start_cyc[k], lit_cnt[k], slot_time(0), DW);
            end
        end
        total++;
        if (o_shift_err !== 1'b0) begin
            bad++;
            $display("FAIL same_err: got %b, required 0", o_shift_err);
        end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        cyc        = 0;
        pend_cnt   = 0;
        stray_cnt  = 0;
        shift_done = 1'b0;
        rst_n      = 1'b0;
        enable     = 1'b0;
        leds_valid = 1'b0;
        for (int i = 0; i < ND; i++) begin
            row_tbl[i]   = '0;
            lat_tbl[i]   = 1;
            stray_tbl[i] = -1;
        end
        clear_log();
        test_reset();
        test_full_frame();
        test_snapshot();
        test_timeout();
        test_enable_drop();
        test_same_cycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
